// File: rtl/hc595_pkg.sv
// Shared constants and types for the 74HC595 display-link receiver and any
// other consumer of active-low 7-segment glyphs.
package hc595_pkg;

  localparam int SEG_W  = 8;
  localparam int SEL_W  = 8;
  localparam int DIGITS = 8;

  // Index of each link wire inside the packed synchroniser vector.
  localparam int LINK_DIO   = 0;
  localparam int LINK_SRCLK = 1;
  localparam int LINK_RCLK  = 2;
  localparam int LINK_N     = 3;

  // Active-low glyphs, bit7 = dp (off), bits6:0 = g..a.
  localparam logic [SEG_W-1:0] SEG_0 = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1 = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2 = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3 = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4 = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5 = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6 = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7 = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8 = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9 = 8'h90;
  localparam logic [SEG_W-1:0] SEG_A = 8'h88;
  localparam logic [SEG_W-1:0] SEG_B = 8'h83;
  localparam logic [SEG_W-1:0] SEG_C = 8'hC6;
  localparam logic [SEG_W-1:0] SEG_D = 8'hA1;
  localparam logic [SEG_W-1:0] SEG_E = 8'h86;
  localparam logic [SEG_W-1:0] SEG_F = 8'h8E;

  typedef logic [SEG_W+SEL_W-1:0] link_word_t;

  function automatic logic is_one_hot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex 7-segment font: maps segments g..a
// (active-low, dp excluded) back to a nibble, with hit low for non-glyphs.
module seg7_decode
  import hc595_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (seg)
      SEG_0[6:0]: nibble = 4'h0;
      SEG_1[6:0]: nibble = 4'h1;
      SEG_2[6:0]: nibble = 4'h2;
      SEG_3[6:0]: nibble = 4'h3;
      SEG_4[6:0]: nibble = 4'h4;
      SEG_5[6:0]: nibble = 4'h5;
      SEG_6[6:0]: nibble = 4'h6;
      SEG_7[6:0]: nibble = 4'h7;
      SEG_8[6:0]: nibble = 4'h8;
      SEG_9[6:0]: nibble = 4'h9;
      SEG_A[6:0]: nibble = 4'hA;
      SEG_B[6:0]: nibble = 4'hB;
      SEG_C[6:0]: nibble = 4'hC;
      SEG_D[6:0]: nibble = 4'hD;
      SEG_E[6:0]: nibble = 4'hE;
      SEG_F[6:0]: nibble = 4'hF;
      default:    hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/hc595_rx.sv
// Receiver for the 74HC595 DIO/SRCLK/RCLK display link: rebuilds the latched
// seg/sel bytes and the 8-digit hex word. HC595_RX_GLITCH_FILTER_EN adds a
// 3-sample glitch filter on every link wire.
module hc595_rx
  import hc595_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                DIO,
  input  logic                SRCLK,
  input  logic                RCLK,
  output logic [SEG_W-1:0]    seg,
  output logic [SEL_W-1:0]    sel,
  output logic                latch_valid,
  output logic [4*DIGITS-1:0] disp_data,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                frame_done,
  output logic                len_err,
  output logic                sel_err,
  output logic                dec_err
);

  logic [LINK_N-1:0]            link_raw;
  logic [LINK_N-1:0]            link_lvl;
  logic [LINK_N-1:1]            link_rise;
  logic                         srclk_rise;
  logic                         rclk_rise;

  assign link_raw = {RCLK, SRCLK, DIO};

  genvar gi;
  for (gi = 0; gi < LINK_N; gi++) begin : g_sync
    logic s1, s2;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= link_raw[gi];
        s2 <= s1;
      end
    end

`ifdef HC595_RX_GLITCH_FILTER_EN
    // hold is both the filtered level and the edge-detect history.
    logic q1, q2, hold;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q1   <= 1'b0;
        q2   <= 1'b0;
        hold <= 1'b0;
      end else begin
        q1   <= s2;
        q2   <= q1;
        hold <= link_lvl[gi];
      end
    end

    assign link_lvl[gi] = (s2 == q1 && q1 == q2) ? s2 : hold;

    if (gi != LINK_DIO) begin : g_edge
      assign link_rise[gi] = link_lvl[gi] & ~hold;
    end
`else
    assign link_lvl[gi] = s2;

    if (gi != LINK_DIO) begin : g_edge
      logic hist;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) hist <= 1'b0;
        else        hist <= link_lvl[gi];
      end

      assign link_rise[gi] = link_lvl[gi] & ~hist;
    end
`endif
  end

  assign srclk_rise = link_rise[LINK_SRCLK];
  assign rclk_rise  = link_rise[LINK_RCLK];

  link_word_t       shreg;
  logic [CNT_W-1:0] bitcnt;

  // Latch reads shreg before this cycle's shift, as the real 74HC595 does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg       <= '0;
      bitcnt      <= '0;
      seg         <= '0;
      sel         <= '0;
      latch_valid <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      latch_valid <= 1'b0;
      len_err     <= 1'b0;
      if (rclk_rise) begin
        {seg, sel}  <= shreg;
        latch_valid <= 1'b1;
        len_err     <= (bitcnt != CNT_W'(16));
      end
      if (srclk_rise) begin
        shreg <= {shreg[SEG_W+SEL_W-2:0], link_lvl[LINK_DIO]};
      end
      if (rclk_rise) begin
        bitcnt <= srclk_rise ? CNT_W'(1) : '0;
      end else if (srclk_rise && bitcnt != {CNT_W{1'b1}}) begin
        bitcnt <= bitcnt + CNT_W'(1);
      end
    end
  end

  logic [3:0]        dec_nibble;
  logic              dec_hit;
  logic [2:0]        sel_idx;
  logic [DIGITS-1:0] dv_base;
  logic [DIGITS-1:0] dv_new;

  seg7_decode u_decode (
    .seg    (seg[6:0]),
    .nibble (dec_nibble),
    .hit    (dec_hit)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) sel_idx = 3'(i);
    end
  end

  // A completed frame is cleared before any new digit is merged in.
  assign dv_base = (digit_valid == '1) ? '0 : digit_valid;
  assign dv_new  = dv_base | sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_data   <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      sel_err     <= 1'b0;
      dec_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sel_err    <= 1'b0;
      dec_err    <= 1'b0;
      digit_valid <= dv_base;
      if (latch_valid) begin
        if (!is_one_hot(sel)) begin
          sel_err <= 1'b1;
        end else if (!dec_hit) begin
          dec_err <= 1'b1;
        end else begin
          disp_data[{sel_idx, 2'b00} +: 4] <= dec_nibble;
          digit_valid <= dv_new;
          frame_done  <= (dv_new == '1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hc595_rx.sv
// Self-checking bench for hc595_rx: directed vector table, hand-written corner
// sequences, then randomized words checked against a behavioural model.
module tb_hc595_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DIO = 1'b0;
  logic        SRCLK = 1'b0;
  logic        RCLK = 1'b0;
  logic [7:0]  seg;
  logic [7:0]  sel;
  logic        latch_valid;
  logic [31:0] disp_data;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        len_err;
  logic        sel_err;
  logic        dec_err;

  hc595_rx #(.CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .DIO         (DIO),
    .SRCLK       (SRCLK),
    .RCLK        (RCLK),
    .seg         (seg),
    .sel         (sel),
    .latch_valid (latch_valid),
    .disp_data   (disp_data),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .len_err     (len_err),
    .sel_err     (sel_err),
    .dec_err     (dec_err)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor, sampled on the falling edge.
  int          n_lv = 0, n_len = 0, n_se = 0, n_de = 0, n_fd = 0;
  logic [7:0]  cap_seg = 0, cap_sel = 0, cap_dv = 0;
  logic [31:0] cap_disp = 0;
  bit          lv_prev = 0;

  always @(negedge clk) begin
    if (latch_valid === 1'b1) begin
      n_lv++;
      cap_seg = seg;
      cap_sel = sel;
    end
    if (lv_prev) begin
      cap_disp = disp_data;
      cap_dv   = digit_valid;
    end
    lv_prev = (latch_valid === 1'b1);
    if (len_err === 1'b1)    n_len++;
    if (sel_err === 1'b1)    n_se++;
    if (dec_err === 1'b1)    n_de++;
    if (frame_done === 1'b1) n_fd++;
  end

  // Behavioural model of the link as the display would see it.
  logic [15:0] m_sh;
  int          m_cnt;
  int          m_nib [8];
  bit          m_val [8];
  logic [7:0]  e_seg, e_sel, e_dv;
  logic [31:0] e_disp;
  int          e_len, e_se, e_de, e_fd;

  task automatic m_reset();
    m_sh = 0;
    m_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      m_nib[k] = 0;
      m_val[k] = 0;
    end
  endtask

  task automatic m_shift(input bit b);
    m_sh = {m_sh[14:0], b};
    if (m_cnt < 31) m_cnt++;
  endtask

  task automatic m_latch();
    int ones, idx, hitk;
    e_seg = m_sh[15:8];
    e_sel = m_sh[7:0];
    e_len = (m_cnt != 16) ? 1 : 0;
    m_cnt = 0;
    e_se = 0; e_de = 0; e_fd = 0;
    ones = 0; idx = 0; hitk = -1;
    for (int k = 0; k < 8; k++) if (e_sel[k]) begin ones++; idx = k; end
    if (ones != 1) e_se = 1;
    else begin
      for (int k = 0; k < 16; k++) if ((e_seg | 8'h80) == GLY[k]) hitk = k;
      if (hitk < 0) e_de = 1;
      else begin
        m_nib[idx] = hitk;
        m_val[idx] = 1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      e_disp[4*k +: 4] = 4'(m_nib[k]);
      e_dv[k] = m_val[k];
    end
    if (e_dv == 8'hFF) begin
      e_fd = 1;
      for (int k = 0; k < 8; k++) m_val[k] = 0;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DIO = v[i];
      repeat (2) @(negedge clk);
      SRCLK = 1'b1;
      m_shift(v[i]);
      repeat (6) @(negedge clk);
      SRCLK = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic latch(input bit simul, input bit b);
    if (simul) begin
      DIO = b;
      repeat (2) @(negedge clk);
      SRCLK = 1'b1;
    end
    RCLK = 1'b1;
    m_latch();
    if (simul) m_shift(b);
    repeat (6) @(negedge clk);
    SRCLK = 1'b0;
    RCLK  = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int d_lv, d_len, d_se, d_de, d_fd;

  task automatic txn(input string t, input logic [63:0] v, input int n, input bit simul, input bit b);
    int s_lv, s_len, s_se, s_de, s_fd;
    s_lv = n_lv; s_len = n_len; s_se = n_se; s_de = n_de; s_fd = n_fd;
    send_bits(v, n);
    latch(simul, b);
    d_lv = n_lv - s_lv; d_len = n_len - s_len; d_se = n_se - s_se;
    d_de = n_de - s_de; d_fd = n_fd - s_fd;
    $display("txn %s bits=%0d simul=%0d seg=%h sel=%h disp=%h dv=%h len=%0d se=%0d de=%0d fd=%0d",
             t, n, simul, cap_seg, cap_sel, cap_disp, cap_dv, d_len, d_se, d_de, d_fd);
  endtask

  task automatic cmp_txn(input string t, input logic [7:0] es, input logic [7:0] esl,
                         input int el, input int ese, input int ede, input int efd,
                         input logic [31:0] ed, input logic [7:0] edv);
    check({t, ".latch_cnt"}, d_lv, 1);
    check({t, ".seg"}, cap_seg, es);
    check({t, ".sel"}, cap_sel, esl);
    check({t, ".len_err"}, d_len, el);
    check({t, ".sel_err"}, d_se, ese);
    check({t, ".dec_err"}, d_de, ede);
    check({t, ".frame_done"}, d_fd, efd);
    check({t, ".disp"}, cap_disp, ed);
    check({t, ".dv"}, cap_dv, edv);
  endtask

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic [7:0]  eseg, esel;
    int          elen, ese, ede, efd;
    logic [31:0] edisp;
    logic [7:0]  edv, edv_after;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [7:0]  rs, rg;
    logic [63:0] v;
    int          n, r;
    bit          sim;

    tbl[0]  = '{16'h9202, 16, 8'h92, 8'h02, 0, 0, 0, 0, 32'h0000_0050, 8'h02, 8'h02};
    tbl[1]  = '{16'hC001, 16, 8'hC0, 8'h01, 0, 0, 0, 0, 32'h0000_0050, 8'h03, 8'h03};
    tbl[2]  = '{16'hF902, 16, 8'hF9, 8'h02, 0, 0, 0, 0, 32'h0000_0010, 8'h03, 8'h03};
    tbl[3]  = '{16'hA404, 16, 8'hA4, 8'h04, 0, 0, 0, 0, 32'h0000_0210, 8'h07, 8'h07};
    tbl[4]  = '{16'hB008, 16, 8'hB0, 8'h08, 0, 0, 0, 0, 32'h0000_3210, 8'h0F, 8'h0F};
    tbl[5]  = '{16'h9910, 16, 8'h99, 8'h10, 0, 0, 0, 0, 32'h0004_3210, 8'h1F, 8'h1F};
    tbl[6]  = '{16'h9220, 16, 8'h92, 8'h20, 0, 0, 0, 0, 32'h0054_3210, 8'h3F, 8'h3F};
    tbl[7]  = '{16'h8240, 16, 8'h82, 8'h40, 0, 0, 0, 0, 32'h0654_3210, 8'h7F, 8'h7F};
    tbl[8]  = '{16'hF880, 16, 8'hF8, 8'h80, 0, 0, 0, 1, 32'h7654_3210, 8'hFF, 8'h00};
    tbl[9]  = '{16'h4002, 15, 8'h40, 8'h02, 1, 0, 0, 0, 32'h7654_3200, 8'h02, 8'h02};
    tbl[10] = '{16'h9904, 16, 8'h99, 8'h04, 0, 0, 0, 0, 32'h7654_3400, 8'h06, 8'h06};
    tbl[11] = '{16'hC003, 16, 8'hC0, 8'h03, 0, 1, 0, 0, 32'h7654_3400, 8'h06, 8'h06};
    tbl[12] = '{16'hFF01, 16, 8'hFF, 8'h01, 0, 0, 1, 0, 32'h7654_3400, 8'h06, 8'h06};

    m_reset();
    repeat (4) @(negedge clk);
    check("reset.seg_sel", {16'h0, seg, sel}, 32'h0);
    check("reset.disp", disp_data, 32'h0);
    check("reset.flags", {19'h0, digit_valid, latch_valid, frame_done, len_err, sel_err, dec_err}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      txn($sformatf("vec%0d", i), {48'h0, tbl[i].word}, tbl[i].nbits, 1'b0, 1'b0);
      cmp_txn($sformatf("vec%0d", i), tbl[i].eseg, tbl[i].esel, tbl[i].elen, tbl[i].ese,
              tbl[i].ede, tbl[i].efd, tbl[i].edisp, tbl[i].edv);
      check($sformatf("vec%0d.dv_after", i), digit_valid, tbl[i].edv_after);
    end

    // Reset in the middle of a word discards it and clears everything at once.
    send_bits(64'hA5, 8);
    #3 reset = 1'b0;
    #1;
    check("midrst.seg_sel", {16'h0, seg, sel}, 32'h0);
    check("midrst.disp", disp_data, 32'h0);
    check("midrst.flags", {19'h0, digit_valid, latch_valid, frame_done, len_err, sel_err, dec_err}, 32'h0);
    m_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    txn("after_rst", 64'h8802, 16, 1'b0, 1'b0);
    cmp_txn("after_rst", 8'h88, 8'h02, 0, 0, 0, 0, 32'h0000_00A0, 8'h02);

    // SRCLK and RCLK together: pre-shift word latched, that bit starts the next word.
    txn("simul", 64'h8608, 16, 1'b1, 1'b1);
    cmp_txn("simul", 8'h86, 8'h08, 0, 0, 0, 0, 32'h0000_E0A0, 8'h0A);
    txn("post_simul", 64'h0610, 15, 1'b0, 1'b0);
    cmp_txn("post_simul", 8'h86, 8'h10, 0, 0, 0, 0, 32'h000E_E0A0, 8'h1A);

`ifdef HC595_RX_GLITCH_FILTER_EN
    DIO = 1'b1;
    repeat (2) @(negedge clk);
    SRCLK = 1'b1;
    repeat (2) @(negedge clk);
    SRCLK = 1'b0;
    repeat (10) @(negedge clk);
    txn("glitch", 64'h8004, 16, 1'b0, 1'b0);
    cmp_txn("glitch", 8'h80, 8'h04, 0, 0, 0, 0, 32'h000E_E8A0, 8'h1E);
`endif

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       rs = 8'h01 << r;
      else if (r == 8) rs = 8'($urandom);
      else             rs = 8'h00;
      if ($urandom_range(0, 5) == 0) rg = 8'($urandom);
      else                           rg = GLY[$urandom_range(0, 15)] ^ ($urandom_range(0, 1) ? 8'h80 : 8'h00);
      v = {32'($urandom), 16'($urandom), rg, rs};
      r = $urandom_range(0, 9);
      if (r == 0)      n = $urandom_range(1, 15);
      else if (r == 1) n = $urandom_range(17, 35);
      else             n = 16;
      sim = ($urandom_range(0, 7) == 0);
      txn($sformatf("rnd%0d", it), v, n, sim, 1'($urandom));
      cmp_txn($sformatf("rnd%0d", it), e_seg, e_sel, e_len, e_se, e_de, e_fd, e_disp, e_dv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
